// File: rtl/ram_stream_reader.sv
// Streams LEN+1 consecutive samples from a 1-cycle-latency block RAM onto a
// valid/ready interface, with optional continuous replay and synchronous abort.
module ram_stream_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk_100M,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic              loop_en,
   input  logic              stop,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, PRESENT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] cnt_max;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] offset_inc;

   assign offset_inc = offset + ADDR_W'(1);

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         base     <= '0;
         cnt_max  <= '0;
         offset   <= '0;
         ram_en   <= 1'b0;
         ram_addr <= '0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         // NOTE: all state updates are non-blocking so every branch below sees
         // the pre-edge values of offset/base, and the done default below is
         // safely overridden by the one branch that raises it.
         done <= 1'b0;
         if (stop) begin
            state   <= IDLE;
            ram_en  <= 1'b0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     base     <= start_addr;
                     cnt_max  <= len;
                     offset   <= '0;
                     ram_addr <= start_addr;
                     ram_en   <= 1'b1;
                     busy     <= 1'b1;
                     state    <= READ;
                  end
               end
               READ: begin
                  ram_en <= 1'b0;
                  state  <= CAPTURE;
               end
               CAPTURE: begin
                  m_data  <= ram_dout;
                  m_valid <= 1'b1;
                  state   <= PRESENT;
               end
               PRESENT: begin
                  if (m_ready) begin
                     m_valid <= 1'b0;
                     if (offset != cnt_max) begin
                        // Address adder is ADDR_W wide; the carry drops, giving the wrap.
                        offset   <= offset_inc;
                        ram_addr <= base + offset_inc;
                        ram_en   <= 1'b1;
                        state    <= READ;
                     end else if (loop_en) begin
                        offset   <= '0;
                        ram_addr <= base;
                        ram_en   <= 1'b1;
                        state    <= READ;
                     end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: RAM model, data/address scoreboards
// and a negedge monitor that checks every stream transfer.
module tb_ram_stream_reader;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;

   logic              clk_100M = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic [ADDR_W-1:0] len = '0;
   logic              loop_en = 1'b0;
   logic              stop = 1'b0;
   logic              ram_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dout = '0;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic              busy;
   logic              done;

   ram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_100M   (clk_100M),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .loop_en    (loop_en),
      .stop       (stop),
      .ram_en     (ram_en),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk_100M = ~clk_100M;

   // RAM model: 2..9 at addresses 0..7, zero elsewhere, 1-cycle read latency.
   logic [DATA_W-1:0] mem [2**ADDR_W];
   initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = (i < 8) ? DATA_W'(i + 2) : '0;
   always @(posedge clk_100M) if (ram_en) ram_dout <= mem[ram_addr];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboards and monitor state.
   logic [DATA_W-1:0] exp_q [$];
   logic [ADDR_W-1:0] addr_q [$];
   logic              addr_chk = 1'b0;
   logic              gap_chk = 1'b0;
   logic              hold_prev = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   int                n_xfer = 0;
   int                n_done = 0;
   int                cyc = 0;
   int                last_xfer_cyc = -1;

   always @(negedge clk_100M) begin
      cyc++;
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (done) n_done++;
         if (ram_en && addr_chk) begin
            check("addr_expected", 32'(addr_q.size() != 0), 1);
            if (addr_q.size() != 0) check("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
         end
         if (hold_prev) begin
            check("hold_valid", 32'(m_valid), 1);
            check("hold_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready && !stop) begin
            check("xfer_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            if (gap_chk && last_xfer_cyc >= 0) check("xfer_gap", 32'(cyc - last_xfer_cyc), 3);
            last_xfer_cyc = cyc;
            n_xfer++;
         end
         hold_prev = m_valid && !m_ready && !stop;
         prev_data = m_data;
      end
   end

   // Stimulus helpers: inputs change 1 ns after each rising edge.
   int rdy_mode = 0;  // 0: always ready, 1: ready 1-of-4 cycles, 2: never ready
   int step_n = 0;

   task automatic step();
      @(posedge clk_100M);
      #1;
      step_n++;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = (step_n % 4 == 0);
         default: m_ready = 1'b0;
      endcase
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l, input logic lp);
      start_addr = a;
      len        = l;
      loop_en    = lp;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
      return (a < 8) ? DATA_W'(a) + DATA_W'(2) : '0;
   endfunction

   task automatic push_run(input logic [ADDR_W-1:0] base, input int cnt, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < cnt; i++) begin
            logic [ADDR_W-1:0] a;
            a = base + ADDR_W'(i);
            addr_q.push_back(a);
            exp_q.push_back(model_data(a));
         end
      end
   endtask

   task automatic wait_xfers(input string tag, input int n, input int budget);
      int target;
      int k;
      target = n_xfer + n;
      k = 0;
      while (n_xfer < target && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(n_xfer >= target), 1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stimulus
      int d0;
      int x0;

      // Reset state.
      step();
      step();
      check("rst_ram_en", 32'(ram_en), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst_n = 1'b1;
      step();

      // 1: 0..7 with ready held high, latency and 3-cycle cadence.
      addr_chk = 1'b1;
      gap_chk  = 1'b1;
      last_xfer_cyc = -1;
      rdy_mode = 0;
      step();
      d0 = n_done;
      push_run(0, 8, 1);
      pulse_start(0, 7, 1'b0);
      check("t1_ram_en_n1", 32'(ram_en), 1);
      check("t1_busy", 32'(busy), 1);
      check("t1_valid_n1", 32'(m_valid), 0);
      step();
      check("t1_ram_en_n2", 32'(ram_en), 0);
      check("t1_valid_n2", 32'(m_valid), 0);
      step();
      check("t1_valid_n3", 32'(m_valid), 1);
      wait_xfers("t1_timeout", 8, 100);
      check("t1_done_pulse", 32'(done), 1);
      check("t1_busy_after", 32'(busy), 0);
      step();
      check("t1_done_cleared", 32'(done), 0);
      check("t1_done_count", 32'(n_done - d0), 1);
      check("t1_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);
      gap_chk = 1'b0;

      // 2: same run with ready 1-of-4; start_addr/len changes while busy ignored.
      rdy_mode = 1;
      d0 = n_done;
      push_run(0, 8, 1);
      pulse_start(0, 7, 1'b0);
      start_addr = 10'd500;
      len        = 10'd2;
      wait_xfers("t2_timeout", 8, 200);
      step();
      step();
      check("t2_done_count", 32'(n_done - d0), 1);
      check("t2_busy_after", 32'(busy), 0);
      check("t2_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);

      // 3: address wrap 1022, 1023, 0, 1.
      rdy_mode = 0;
      d0 = n_done;
      push_run(10'd1022, 4, 1);
      pulse_start(10'd1022, 10'd3, 1'b0);
      wait_xfers("t3_timeout", 4, 60);
      step();
      check("t3_done_count", 32'(n_done - d0), 1);
      check("t3_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);

      // 4: loop mode 8,9,8,9 then stop; no done.
      d0 = n_done;
      push_run(10'd6, 2, 2);
      addr_q.push_back(10'd6);  // the replay read already issued when stop lands
      pulse_start(10'd6, 10'd1, 1'b1);
      wait_xfers("t4_timeout", 4, 60);
      check("t4_busy_looping", 32'(busy), 1);
      check("t4_ram_en_looping", 32'(ram_en), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t4_stop_valid", 32'(m_valid), 0);
      check("t4_stop_busy", 32'(busy), 0);
      check("t4_stop_ram_en", 32'(ram_en), 0);
      check("t4_stop_done", 32'(done), 0);
      step();
      step();
      step();
      check("t4_no_done", 32'(n_done - d0), 0);
      check("t4_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);

      // Start and stop together in IDLE: stop wins.
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("ss_busy", 32'(busy), 0);
      check("ss_ram_en", 32'(ram_en), 0);

      // 5: len=0 gives one sample; a second start mid-run is ignored.
      d0 = n_done;
      x0 = n_xfer;
      push_run(10'd4, 1, 1);
      pulse_start(10'd4, 10'd0, 1'b0);
      pulse_start(10'd0, 10'd7, 1'b0);
      wait_xfers("t5_timeout", 1, 30);
      check("t5_done_pulse", 32'(done), 1);
      for (int i = 0; i < 8; i++) step();
      check("t5_single_xfer", 32'(n_xfer - x0), 1);
      check("t5_done_count", 32'(n_done - d0), 1);
      check("t5_busy_after", 32'(busy), 0);

      // 6: asynchronous reset while presenting, then a fresh run.
      rdy_mode = 2;
      d0 = n_done;
      addr_q.push_back(10'd0);
      pulse_start(10'd0, 10'd7, 1'b0);
      step();
      step();
      check("t6_pre_valid", 32'(m_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_ram_en", 32'(ram_en), 0);
      check("t6_rst_ram_addr", 32'(ram_addr), 0);
      check("t6_rst_m_data", 32'(m_data), 0);
      check("t6_rst_m_valid", 32'(m_valid), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_done", 32'(done), 0);
      @(negedge clk_100M);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      step();
      step();
      check("t6_no_done", 32'(n_done - d0), 0);
      push_run(10'd0, 2, 1);
      pulse_start(10'd0, 10'd1, 1'b0);
      wait_xfers("t6_timeout", 2, 40);
      step();
      check("t6_done_count", 32'(n_done - d0), 1);
      check("t6_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
